// File: rtl/apb_pkg.sv
// Shared definitions for the APB command master: FSM state encoding and
// default bus geometry / PREADY timeout.
package apb_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 16;

    // Wait counter is sized for the largest legal TIMEOUT (255).
    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_int_sync.sv
// Two-flop synchronizer for the active-low slave interrupt plus the sticky
// irq_pending flag; a synchronized low level outranks a simultaneous clear.
module apb_int_sync (
    input  logic SYSCLK,
    input  logic PRESETN,
    input  logic INT_B,
    input  logic irq_clr,
    output logic irq_pending
);

    logic sync1_q;
    logic sync1_d;
    logic sync2_q;
    logic sync2_d;
    logic pend_q;
    logic pend_d;

    always_ff @(posedge SYSCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            pend_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        sync1_d = INT_B;
        sync2_d = sync1_q;
        pend_d  = pend_q;
        if (irq_clr) begin
            pend_d = 1'b0;
        end
        if (!sync2_q) begin
            pend_d = 1'b1;
        end
    end

    assign irq_pending = pend_q;

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB master driven by a valid/ready command port, with a
// PREADY timeout, response port, transaction counter and interrupt flag.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | cmd_ready high, waiting for a command
//   ST_SETUP  | APB setup phase (PSEL=1, PENABLE=0), one cycle
//   ST_ACCESS | APB access phase, waiting on PREADY or timeout
//   ST_RESP   | rsp_valid high, waiting for rsp_ready
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              SYSCLK,
    input  logic              PRESETN,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,

    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,

    input  logic              INT_B,
    output logic              irq_pending,
    input  logic              irq_clr,

    output logic [7:0]        txn_count
);

    apb_state_e        state_q;
    apb_state_e        state_d;
    logic [ADDR_W-1:0] paddr_q;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] pwdata_d;
    logic              pwrite_q;
    logic              pwrite_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic              err_q;
    logic              err_d;
    logic              tmo_q;
    logic              tmo_d;
    logic [7:0]        cnt_q;
    logic [7:0]        cnt_d;

    // The last PREADY-low cycle that still counts as waiting.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    always_ff @(posedge SYSCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q  <= ST_IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            wait_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            wait_q   <= wait_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        wait_d   = wait_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pwrite_d = cmd_write;
                    wait_d   = '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY on the final allowed cycle still completes normally.
                if (PREADY) begin
                    rdata_d = pwrite_q ? '0 : PRDATA;
                    err_d   = PSLVERR;
                    tmo_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_q == WAIT_LAST) begin
                        rdata_d = '0;
                        err_d   = 1'b0;
                        tmo_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign PSEL        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE     = (state_q == ST_ACCESS);
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tmo_q;
    assign txn_count   = cnt_q;

    apb_int_sync u_int_sync (
        .SYSCLK      (SYSCLK),
        .PRESETN     (PRESETN),
        .INT_B       (INT_B),
        .irq_clr     (irq_clr),
        .irq_pending (irq_pending)
    );

endmodule
